// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding unit.
package hazard_pkg;

  localparam int unsigned FWD_W = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MULTI = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MW = 2'b10;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side bundle of hazard inputs and stage-control / forwarding outputs.
interface hazard_fwd_unit_if #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
);

  logic [1:0]                      pc_src;
  logic                            halt;
  logic [REG_AW-1:0]               id_rs, id_rt;
  logic                            id_rs_used, id_rt_used;
  logic [REG_AW-1:0]               ex_rs, ex_rt, ex_rd;
  logic                            ex_reg_write, ex_mem_read, ex_multi;
  logic [REG_AW-1:0]               mem_rd;
  logic                            mem_reg_write;
  logic [REG_AW-1:0]               wb_rd;
  logic                            wb_reg_write;
  logic                            imem_busy, dmem_busy;

  logic                            pc_hold, fd_hold, de_hold;
  logic                            fd_nop, de_nop, em_nop;
  logic [hazard_pkg::FWD_W-1:0]    fwd_a, fwd_b;
  logic                            halted;
  logic [CNT_W-1:0]                stall_cycles;

  modport master (
    output pc_src, halt, id_rs, id_rt, id_rs_used, id_rt_used,
           ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_multi,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, imem_busy, dmem_busy,
    input  pc_hold, fd_hold, de_hold, fd_nop, de_nop, em_nop,
           fwd_a, fwd_b, halted, stall_cycles
  );

  modport slave (
    input  pc_src, halt, id_rs, id_rt, id_rs_used, id_rt_used,
           ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_multi,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, imem_busy, dmem_busy,
    output pc_hold, fd_hold, de_hold, fd_nop, de_nop, em_nop,
           fwd_a, fwd_b, halted, stall_cycles
  );

endinterface

// File: rtl/hazard_stall_ctr.sv
// Saturating counter of cycles in which the PC was held.
module hazard_stall_ctr #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection, stall/flush sequencing and ALU operand forwarding for a
// five-stage pipeline with a multicycle EX unit.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned MUL_LAT  = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  hazard_fwd_unit_if.slave bus
);

  localparam int unsigned          MCNT_W    = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [MCNT_W-1:0]    MCNT_LOAD = MCNT_W'(MUL_LAT - 2);

  state_e            state, state_n, cur;
  logic [MCNT_W-1:0] mcnt, mcnt_n, mcnt_cur;
  logic              taken, load_use;
  logic              pc_hold_c, fd_hold_c, de_hold_c;
  logic              fd_nop_c, de_nop_c, em_nop_c;
  logic [FWD_W-1:0]  fwd_a_c, fwd_b_c;

  // Destination y matches source x unless y is a hardwired zero register.
  function automatic logic reg_match(input logic [REG_AW-1:0] x, input logic [REG_AW-1:0] y);
    return (x == y) && !((ZERO_REG != 0) && (y == '0));
  endfunction

  // The reset cycle is evaluated as if already in RUN.
  assign cur      = rst ? RUN : state;
  assign mcnt_cur = rst ? '0  : mcnt;

  assign taken    = bus.pc_src[1];
  assign load_use = bus.ex_mem_read && bus.ex_reg_write &&
                    ((bus.id_rs_used && reg_match(bus.id_rs, bus.ex_rd)) ||
                     (bus.id_rt_used && reg_match(bus.id_rt, bus.ex_rd)));

  always_comb begin
    fwd_a_c = FWD_RF;
    fwd_b_c = FWD_RF;
    if (bus.mem_reg_write && reg_match(bus.ex_rs, bus.mem_rd))      fwd_a_c = FWD_EM;
    else if (bus.wb_reg_write && reg_match(bus.ex_rs, bus.wb_rd))   fwd_a_c = FWD_MW;
    if (bus.mem_reg_write && reg_match(bus.ex_rt, bus.mem_rd))      fwd_b_c = FWD_EM;
    else if (bus.wb_reg_write && reg_match(bus.ex_rt, bus.wb_rd))   fwd_b_c = FWD_MW;
  end

  // Next-state and stage-control decode in priority order.
  always_comb begin
    state_n   = cur;
    mcnt_n    = mcnt_cur;
    pc_hold_c = 1'b0;
    fd_hold_c = 1'b0;
    de_hold_c = 1'b0;
    fd_nop_c  = 1'b0;
    de_nop_c  = 1'b0;
    em_nop_c  = 1'b0;
    if (cur == HALT) begin
      pc_hold_c = 1'b1;
      fd_hold_c = 1'b1;
      de_hold_c = 1'b1;
      fd_nop_c  = 1'b1;
    end else if (bus.dmem_busy) begin
      pc_hold_c = 1'b1;
      fd_hold_c = 1'b1;
      de_hold_c = 1'b1;
    end else begin
      if (taken) begin
        fd_nop_c = 1'b1;
        de_nop_c = 1'b1;
        em_nop_c = 1'b1;
        state_n  = RUN;
        mcnt_n   = '0;
      end else if (cur == MULTI) begin
        if (mcnt_cur != '0) begin
          pc_hold_c = 1'b1;
          fd_hold_c = 1'b1;
          de_hold_c = 1'b1;
          em_nop_c  = 1'b1;
          mcnt_n    = mcnt_cur - MCNT_W'(1);
        end else begin
          state_n = RUN;
        end
      end else if (bus.ex_multi) begin
        pc_hold_c = 1'b1;
        fd_hold_c = 1'b1;
        de_hold_c = 1'b1;
        em_nop_c  = 1'b1;
        mcnt_n    = MCNT_LOAD;
        state_n   = MULTI;
      end else if (load_use) begin
        pc_hold_c = 1'b1;
        fd_hold_c = 1'b1;
        de_nop_c  = 1'b1;
      end else if (bus.imem_busy) begin
        pc_hold_c = 1'b1;
        fd_nop_c  = 1'b1;
      end
      if ((cur == RUN) && bus.halt) begin
        state_n = HALT;
        mcnt_n  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      mcnt  <= '0;
    end else begin
      state <= state_n;
      mcnt  <= mcnt_n;
    end
  end

  hazard_stall_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_hold_c),
    .count (bus.stall_cycles)
  );

  assign bus.pc_hold = pc_hold_c;
  assign bus.fd_hold = fd_hold_c;
  assign bus.de_hold = de_hold_c;
  assign bus.fd_nop  = fd_nop_c;
  assign bus.de_nop  = de_nop_c;
  assign bus.em_nop  = em_nop_c;
  assign bus.fwd_a   = fwd_a_c;
  assign bus.fwd_b   = fwd_b_c;
  assign bus.halted  = (cur == HALT);

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed scenarios plus random traffic checked
// every cycle against an occupancy-based behavioural model.
module tb_hazard_fwd_unit;

  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int ZR      = 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  hazard_fwd_unit_if #(.REG_AW(3), .CNT_W(CNT_W)) bus ();

  hazard_fwd_unit #(.REG_AW(3), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W), .ZERO_REG(ZR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_halted = 0;
  int m_occ    = 0;   // remaining EX cycles of an in-flight multicycle op
  int m_cnt    = 0;
  bit chk_en   = 0;

  function automatic bit mt(int x, int y);
    return (x == y) && !(ZR != 0 && y == 0);
  endfunction

  function automatic int fwd_exp(int src);
    if (bus.mem_reg_write && mt(src, int'(bus.mem_rd))) return 1;
    if (bus.wb_reg_write && mt(src, int'(bus.wb_rd)))   return 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      bit h;
      int occ;
      bit e_ph, e_fh, e_dh, e_fn, e_dn, e_en, lu;
      h   = rst ? 1'b0 : m_halted;
      occ = rst ? 0 : m_occ;
      {e_ph, e_fh, e_dh, e_fn, e_dn, e_en} = '0;
      lu = bus.ex_mem_read && bus.ex_reg_write &&
           ((bus.id_rs_used && mt(int'(bus.id_rs), int'(bus.ex_rd))) ||
            (bus.id_rt_used && mt(int'(bus.id_rt), int'(bus.ex_rd))));
      if (h) begin
        {e_ph, e_fh, e_dh, e_fn} = 4'b1111;
      end else if (bus.dmem_busy) begin
        {e_ph, e_fh, e_dh} = 3'b111;
      end else if (bus.pc_src >= 2) begin
        {e_fn, e_dn, e_en} = 3'b111;
      end else if (occ > 1 || (occ == 0 && bus.ex_multi)) begin
        {e_ph, e_fh, e_dh, e_en} = 4'b1111;
      end else if (occ == 1) begin
        // release cycle: op leaves EX, nothing else acts
      end else if (lu) begin
        {e_ph, e_fh, e_dn} = 3'b111;
      end else if (bus.imem_busy) begin
        {e_ph, e_fn} = 2'b11;
      end
      chk("pc_hold", 32'(bus.pc_hold), 32'(e_ph));
      chk("fd_hold", 32'(bus.fd_hold), 32'(e_fh));
      chk("de_hold", 32'(bus.de_hold), 32'(e_dh));
      chk("fd_nop",  32'(bus.fd_nop),  32'(e_fn));
      chk("de_nop",  32'(bus.de_nop),  32'(e_dn));
      chk("em_nop",  32'(bus.em_nop),  32'(e_en));
      chk("halted",  32'(bus.halted),  32'(h));
      chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_cnt));
      if (!h) begin
        chk("fwd_a", 32'(bus.fwd_a), 32'(fwd_exp(int'(bus.ex_rs))));
        chk("fwd_b", 32'(bus.fwd_b), 32'(fwd_exp(int'(bus.ex_rt))));
      end
      // advance the model across the coming edge
      if (rst) begin
        m_halted = 0; m_occ = 0; m_cnt = 0;
      end else begin
        if (e_ph && m_cnt < CNT_MAX) m_cnt++;
        if (!h && !bus.dmem_busy) begin
          if (bus.pc_src >= 2)               m_occ = 0;
          else if (occ > 0)                  m_occ = occ - 1;
          else if (bus.ex_multi)             m_occ = MUL_LAT - 1;
          if (occ == 0 && bus.halt) begin m_halted = 1; m_occ = 0; end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    bus.pc_src = 2'b00; bus.halt = 1'b0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rs_used = 1'b0; bus.id_rt_used = 1'b0;
    bus.ex_rs = '0; bus.ex_rt = '0; bus.ex_rd = '0;
    bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_multi = 1'b0;
    bus.mem_rd = '0; bus.mem_reg_write = 1'b0; bus.wb_rd = '0; bus.wb_reg_write = 1'b0;
    bus.imem_busy = 1'b0; bus.dmem_busy = 1'b0;
  endtask

  task automatic multi_chk(input string nm, input logic exp_hold);
    #2;
    chk({nm, "_pc_hold"}, 32'(bus.pc_hold), 32'(exp_hold));
    chk({nm, "_em_nop"},  32'(bus.em_nop),  32'(exp_hold));
  endtask

  initial begin
    clr();
    rst = 1'b1;
    step();
    chk_en = 1;
    step();
    #2;
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_stall", 32'(bus.stall_cycles), 0);
    rst = 1'b0;
    step();

    // load-use on rs
    bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_rd = 3; bus.id_rs = 3; bus.id_rs_used = 1;
    #2;
    chk("lu_pc_hold", 32'(bus.pc_hold), 1);
    chk("lu_fd_hold", 32'(bus.fd_hold), 1);
    chk("lu_de_nop",  32'(bus.de_nop), 1);
    step(); clr(); #2;
    chk("lu_release", 32'(bus.pc_hold), 0);
    chk("lu_stall",   32'(bus.stall_cycles), 1);

    // forwarding priority and zero register
    bus.ex_rs = 5; bus.mem_rd = 5; bus.mem_reg_write = 1; bus.wb_rd = 5; bus.wb_reg_write = 1;
    #1 chk("fwd_em_first", 32'(bus.fwd_a), 1);
    bus.mem_reg_write = 0;
    #1 chk("fwd_mw", 32'(bus.fwd_a), 2);
    bus.ex_rt = 0; bus.mem_rd = 0; bus.mem_reg_write = 1;
    #1 chk("fwd_zero_reg", 32'(bus.fwd_b), 0);
    step(); clr();

    // multicycle op: 3 hold cycles, released in the 4th
    bus.ex_multi = 1; multi_chk("mul_c0", 1);
    step(); bus.ex_multi = 0; multi_chk("mul_c1", 1);
    step(); multi_chk("mul_c2", 1);
    step(); bus.ex_multi = 1; multi_chk("mul_c3_release", 0);
    step(); bus.ex_multi = 0; multi_chk("mul_after", 0);
    chk("mul_stall", 32'(bus.stall_cycles), 4);

    // freeze for 2 cycles inside MULTI extends it by 2
    step(); bus.ex_multi = 1; multi_chk("frz_c0", 1);
    step(); bus.ex_multi = 0; multi_chk("frz_c1", 1);
    step(); bus.dmem_busy = 1; #2;
    chk("frz_de_hold", 32'(bus.de_hold), 1);
    chk("frz_em_nop",  32'(bus.em_nop), 0);
    step(); #2 chk("frz_hold2", 32'(bus.pc_hold), 1);
    step(); bus.dmem_busy = 0; multi_chk("frz_c2", 1);
    step(); multi_chk("frz_release", 0);
    chk("frz_stall", 32'(bus.stall_cycles), 9);

    // branch in the same cycle as a multicycle start
    step(); bus.pc_src = 2'b10; bus.ex_multi = 1; #2;
    chk("br_nops", 32'({bus.fd_nop, bus.de_nop, bus.em_nop}), 7);
    chk("br_holds", 32'({bus.pc_hold, bus.fd_hold, bus.de_hold}), 0);
    step(); clr(); #2 chk("br_stays_run", 32'(bus.pc_hold), 0);

    // random traffic, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      step();
      rst              = ($urandom_range(0, 39) == 0);
      bus.pc_src       = 2'($urandom_range(0, 5) == 0 ? $urandom_range(2, 3) : $urandom_range(0, 1));
      bus.ex_multi     = ($urandom_range(0, 7) == 0);
      bus.dmem_busy    = ($urandom_range(0, 5) == 0);
      bus.imem_busy    = ($urandom_range(0, 3) == 0);
      bus.halt         = (bus.pc_src < 2) && !bus.ex_multi && ($urandom_range(0, 59) == 0);
      bus.id_rs        = 3'($urandom); bus.id_rt = 3'($urandom);
      bus.id_rs_used   = 1'($urandom); bus.id_rt_used = 1'($urandom);
      bus.ex_rs        = 3'($urandom); bus.ex_rt = 3'($urandom); bus.ex_rd = 3'($urandom);
      bus.ex_reg_write = 1'($urandom); bus.ex_mem_read = 1'($urandom);
      bus.mem_rd       = 3'($urandom); bus.mem_reg_write = 1'($urandom);
      bus.wb_rd        = 3'($urandom); bus.wb_reg_write = 1'($urandom);
    end

    // counter saturation
    step(); clr(); rst = 1;
    step(); rst = 0; bus.imem_busy = 1;
    for (int i = 0; i < 20; i++) step();
    bus.imem_busy = 0; #2;
    chk("sat_stall", 32'(bus.stall_cycles), 15);

    // halt persists regardless of inputs until reset
    step(); bus.halt = 1;
    step(); bus.halt = 0; bus.pc_src = 2'b11; bus.ex_multi = 1; #2;
    chk("halt_halted", 32'(bus.halted), 1);
    chk("halt_holds", 32'({bus.pc_hold, bus.fd_hold, bus.de_hold, bus.fd_nop}), 15);
    chk("halt_em_nop", 32'(bus.em_nop), 0);
    step(); step(); #2 chk("halt_persist", 32'(bus.halted), 1);
    clr(); rst = 1;
    step(); rst = 0; #2;
    chk("halt_reset", 32'(bus.halted), 0);
    chk("halt_reset_stall", 32'(bus.stall_cycles), 0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter REG_AW, default 3: register-specifier width.
REQ-002 Parameter MUL_LAT, default 4: total EX-stage cycles of a multicycle op; legal values are 2 or more.
REQ-003 Parameter CNT_W, default 16: stall-statistics counter width.
REQ-004 Parameter ZERO_REG, default 0: when 1, register 0 is hardwired and a destination of 0 never matches.
REQ-005 Clock and reset are fixed as follows:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
REQ-006 Control and operand inputs:
- pc_src, input, 2: 2'b10 or 2'b11 means taken branch/jump resolved in MEM.
- halt, input, 1: createdump decoded in ID.
- id_rs, id_rt, input, REG_AW: IF/ID source specifiers.
- id_rs_used, id_rt_used, input, 1: the ID instruction reads that source.
- ex_rs, ex_rt, input, REG_AW: ID/EX source specifiers.
- ex_rd, input, REG_AW; ex_reg_write, ex_mem_read, ex_multi, input, 1: ID/EX destination and controls.
- mem_rd, input, REG_AW; mem_reg_write, input, 1: EX/MEM destination and write enable.
- wb_rd, input, REG_AW; wb_reg_write, input, 1: MEM/WB destination and write enable.
- imem_busy, dmem_busy, input, 1: memory not ready this cycle.
REQ-007 Outputs:
- pc_hold, fd_hold, de_hold, output, 1: stage-register enables are inhibited.
- fd_nop, de_nop, em_nop, output, 1: a bubble is written into that pipeline register.
- fwd_a, fwd_b, output, 2: ALU operand select; 00 is regfile, 01 is EX/MEM, 10 is MEM/WB.
- halted, output, 1: HALT state.
- stall_cycles, output, CNT_W: saturating count of pc_hold cycles.

Function
REQ-008 FSM states SHALL be RUN, MULTI and HALT, with a down-counter mcnt of width clog2(MUL_LAT).
REQ-009 "match(x,y)" SHALL mean x==y and not (ZERO_REG and y==0).
REQ-010 fwd_a SHALL be 01 if mem_reg_write and match(ex_rs, mem_rd); otherwise 10 if wb_reg_write and match(ex_rs, wb_rd); otherwise 00. fwd_b SHALL follow the same rule using ex_rt.
REQ-011 fwd_a and fwd_b SHALL be combinational, independent of FSM state, and valid whenever halted is 0.
REQ-012 Priority, highest first: rst, HALT, dmem_busy, taken branch, MULTI/multicycle start, load-use, imem_busy.
REQ-013 In HALT, pc_hold, fd_hold and de_hold SHALL be 1, fd_nop SHALL be 1, and the state SHALL remain HALT until rst.
REQ-014 In RUN with halt=1 and no freeze, the unit SHALL enter HALT on the next edge.
REQ-015 dmem_busy=1 (freeze): all holds SHALL be 1 and all nops SHALL be 0. FSM state and mcnt SHALL not change. Inputs are held stable by the frozen pipeline.
REQ-016 Taken branch: fd_nop, de_nop and em_nop SHALL be 1 and all holds SHALL be 0. The state SHALL go to RUN, aborting any MULTI, because the flushed EX op is killed.
REQ-017 RUN with ex_multi=1: pc_hold, fd_hold, de_hold and em_nop SHALL be 1, mcnt SHALL be loaded with MUL_LAT-2, and the state SHALL go to MULTI.
REQ-018 MULTI with mcnt != 0: the same outputs as REQ-017 SHALL be driven, and mcnt SHALL decrement.
REQ-019 MULTI with mcnt == 0: no hold and no em_nop SHALL be driven, and the state SHALL go to RUN. This gives exactly MUL_LAT cycles of EX occupancy; ex_multi is ignored in this cycle.
REQ-020 Load-use, in RUN: if ex_mem_read and ex_reg_write and ((id_rs_used and match(id_rs, ex_rd)) or (id_rt_used and match(id_rt, ex_rd))), then pc_hold=1, fd_hold=1 and de_nop=1 for exactly one cycle.
REQ-021 imem_busy, in RUN with no higher-priority condition: pc_hold=1 and fd_nop=1, and the downstream stages flow.
REQ-022 stall_cycles SHALL increment by 1 on every edge where pc_hold=1 and SHALL saturate at all ones.
REQ-023 All outputs not named by an active condition SHALL be 0.

Reset
REQ-024 On rst: the state SHALL be RUN, mcnt 0 and stall_cycles 0. Reset overrides every input, including mid-MULTI and in HALT.
REQ-025 In the reset cycle, outputs SHALL evaluate as RUN with combinational inputs.

Structure
REQ-026 Package hazard_pkg SHALL hold the state enum and the fwd select constants FWD_RF, FWD_EM and FWD_MW.
REQ-027 The saturating statistics counter SHALL be sub-module hazard_stall_ctr, parameterised by CNT_W.

Verification
REQ-028 Load-use:
- Stimulus: ex_mem_read=1, ex_reg_write=1, ex_rd=3, id_rs=3, id_rs_used=1.
- Response: pc_hold, fd_hold and de_nop are 1 for one cycle, and stall_cycles=1.
REQ-029 Forwarding priority:
- Stimulus: ex_rs=5, mem_rd=5, mem_reg_write=1, wb_rd=5, wb_reg_write=1.
- Response: fwd_a=01; with mem_reg_write=0, fwd_a=10.
REQ-030 Multicycle op:
- Stimulus: MUL_LAT=4, ex_multi pulse.
- Response: holds and em_nop are 1 for 3 cycles, released in the 4th, and state is back to RUN.
REQ-031 Freeze inside MULTI:
- Stimulus: dmem_busy=1 for 2 cycles mid-MULTI.
- Response: mcnt is unchanged and MULTI lasts 2 cycles longer.
REQ-032 Branch versus multicycle:
- Stimulus: pc_src=2'b10 in the same cycle as ex_multi=1.
- Response: all three nops are 1, no holds, and state stays RUN.
REQ-033 Halt, saturation and reset:
- Halt: halt=1 gives halted=1 and holds persisting; rst gives state RUN.
- Saturation: with CNT_W=4, 20 stall cycles give stall_cycles=15.
